// File: rtl/nvram_xfer_arbiter_if.sv
// Bus bundle for nvram_xfer_arbiter: HPS ioctl side, pause handshake,
// CPU-side RAM port, physical CMOS RAM port and status flags.
// slave  = the arbiter's view; master = the surrounding core / bench.
`timescale 1ns/1ps
interface nvram_xfer_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  logic              ioctl_download;
  logic              ioctl_upload;
  logic [15:0]       ioctl_index;
  logic              ioctl_wr;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              pause_request;
  logic              pause_cpu;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;
  logic              nvram_dirty;

  modport slave (
    input  ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_rd,
    input  ioctl_addr, ioctl_dout, pause_cpu, cpu_addr, cpu_we, cpu_din, ram_dout,
    output ioctl_din, ioctl_wait, pause_request, cpu_dout,
    output ram_addr, ram_we, ram_din, busy, nvram_dirty
  );

  modport master (
    output ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_rd,
    output ioctl_addr, ioctl_dout, pause_cpu, cpu_addr, cpu_we, cpu_din, ram_dout,
    input  ioctl_din, ioctl_wait, pause_request, cpu_dout,
    input  ram_addr, ram_we, ram_din, busy, nvram_dirty
  );
endinterface

// File: rtl/nvram_xfer_arbiter.sv
// nvram_xfer_arbiter: hands the CMOS RAM port between the CPU and the HPS
// ioctl path for NVRAM load/save. The CPU is paused around every transfer.
// Optional macro NVRAM_DIRTY_EN builds the "CPU modified RAM" flag; when
// undefined nvram_dirty is tied low.
`timescale 1ns/1ps
module nvram_xfer_arbiter #(
  parameter int NVRAM_INDEX = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 4,
  parameter int TIMEOUT     = 4095
) (
  input logic                 clk_sys,
  input logic                 reset,
  nvram_xfer_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_GRANT, S_XFER, S_DRAIN, S_RELEASE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rd_vld_p0;
  logic              r_rd_vld_p1;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_oor;
  logic [7:0]        r_din;
  logic [DATA_W-1:0] r_cpu_dout;

  logic w_sel;
  logic w_addr_ok;
  logic w_cpu_owns;
  logic w_rd_pend;
  logic w_wr_en;
  logic w_rd_acc;
  logic w_unused_hi;

  // Upload byte: RAM nibble zero-extended, out-of-range reads return zero.
  function automatic logic [7:0] fmt_din(input logic oor, input logic [DATA_W-1:0] d);
    logic [7:0] v;
    v = '0;
    v[DATA_W-1:0] = d;
    return oor ? 8'h00 : v;
  endfunction

  assign w_sel       = (bus.ioctl_index == 16'(NVRAM_INDEX)) &
                       (bus.ioctl_download | bus.ioctl_upload);
  assign w_addr_ok   = ~|bus.ioctl_addr[24:ADDR_W];
  assign w_cpu_owns  = (r_state == S_IDLE) | (r_state == S_REQ) | (r_state == S_RELEASE);
  assign w_rd_pend   = r_rd_vld_p0 | r_rd_vld_p1;
  // A write always beats a simultaneous read; no new access while a read is in flight.
  assign w_wr_en     = (r_state == S_XFER) & bus.ioctl_wr & w_addr_ok & ~w_rd_pend;
  assign w_rd_acc    = (r_state == S_XFER) & bus.ioctl_rd & ~bus.ioctl_wr & ~w_rd_pend;
  assign w_unused_hi = &{1'b0, bus.ioctl_dout[7:DATA_W]};
  assign bus.ioctl_din = r_din;

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Pause-acknowledge timeout counter, only runs while requesting.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                 r_cnt <= '0;
    else if (r_state == S_REQ) r_cnt <= r_cnt + 1'b1;
    else                       r_cnt <= '0;
  end

  // Next state, RAM port mux and handshake outputs.
  always_comb begin
    w_next            = r_state;
    bus.pause_request = 1'b0;
    bus.ioctl_wait    = 1'b0;
    bus.busy          = 1'b0;
    bus.ram_addr      = bus.cpu_addr;
    bus.ram_we        = bus.cpu_we & ~reset;
    bus.ram_din       = bus.cpu_din;
    bus.cpu_dout      = r_cpu_dout;
    case (r_state)
      S_IDLE: begin
        bus.cpu_dout   = bus.ram_dout;
        bus.ioctl_wait = w_sel & ~reset;
        if (w_sel) w_next = S_REQ;
      end
      S_REQ: begin
        bus.cpu_dout      = bus.ram_dout;
        bus.pause_request = 1'b1;
        bus.ioctl_wait    = 1'b1;
        if (!w_sel)                                       w_next = S_RELEASE;
        else if (bus.pause_cpu || r_cnt == CNT_W'(TIMEOUT)) w_next = S_GRANT;
      end
      S_GRANT: begin
        bus.busy          = 1'b1;
        bus.pause_request = 1'b1;
        bus.ioctl_wait    = 1'b1;
        bus.ram_addr      = bus.ioctl_addr[ADDR_W-1:0];
        bus.ram_din       = bus.ioctl_dout[DATA_W-1:0];
        bus.ram_we        = 1'b0;
        w_next            = S_XFER;
      end
      S_XFER: begin
        bus.busy          = 1'b1;
        bus.pause_request = 1'b1;
        bus.ioctl_wait    = w_rd_pend;
        bus.ram_addr      = w_rd_pend ? r_rd_addr : bus.ioctl_addr[ADDR_W-1:0];
        bus.ram_din       = bus.ioctl_dout[DATA_W-1:0];
        bus.ram_we        = w_wr_en;
        if (!w_sel) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        bus.busy          = 1'b1;
        bus.pause_request = 1'b1;
        bus.ram_addr      = bus.ioctl_addr[ADDR_W-1:0];
        bus.ram_din       = bus.ioctl_dout[DATA_W-1:0];
        bus.ram_we        = 1'b0;
        w_next            = S_RELEASE;
      end
      S_RELEASE: begin
        bus.cpu_dout = bus.ram_dout;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Upload read sequencer: p0 = address cycle, p1 = RAM read cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rd_vld_p0 <= 1'b0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p0 <= w_rd_acc;
      r_rd_vld_p1 <= r_rd_vld_p0 & (r_state == S_XFER);
    end
  end

  // Latch the upload address at acceptance.
  always_ff @(posedge clk_sys) begin
    if (w_rd_acc) begin
      r_rd_addr <= bus.ioctl_addr[ADDR_W-1:0];
      r_rd_oor  <= ~w_addr_ok;
    end
  end

  // Register the upload byte at the end of the RAM read cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                 r_din <= 8'h00;
    else if (r_rd_vld_p1 && r_state == S_XFER) r_din <= fmt_din(r_rd_oor, bus.ram_dout);
  end

  // Remember what the CPU last read so it sees a stable value while paused.
  always_ff @(posedge clk_sys) begin
    if (w_cpu_owns) r_cpu_dout <= bus.ram_dout;
  end

`ifdef NVRAM_DIRTY_EN
  logic r_dirty;
  logic r_xfer_seen;

  // Dirty flag: set by a changing CPU write, cleared once a transfer completes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dirty     <= 1'b0;
      r_xfer_seen <= 1'b0;
    end else begin
      if (r_state == S_XFER) r_xfer_seen <= 1'b1;
      else if (r_state == S_RELEASE) r_xfer_seen <= 1'b0;
      if (r_state == S_RELEASE && r_xfer_seen) r_dirty <= 1'b0;
      else if (r_state == S_IDLE && bus.cpu_we && bus.cpu_din != bus.ram_dout) r_dirty <= 1'b1;
    end
  end

  assign bus.nvram_dirty = r_dirty;
`else
  assign bus.nvram_dirty = 1'b0;
`endif

endmodule
